spi_flash_arbiter: RTL

- Shares the single spi_flash_read engine between two requesters.
  - Port A is the CPU bus port: single-word reads for instruction/data fetch from the flash window.
  - Port B is a bulk loader port: multi-word burst copies, e.g. flash-to-RAM or sprite/font fetch for video.
- Sits between the SoC address decoder / loader and spi_flash_read, replacing the direct start/strobe wiring.
- Chops long B bursts into bounded chunks so CPU fetch latency stays bounded.

---
 rtl/spi_flash_arb_pkg.sv | 21 ++
 rtl/spi_flash_burst_tracker.sv | 51 +++++
 rtl/spi_flash_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/spi_flash_arb_pkg.sv
// rtl/spi_flash_arb_pkg.sv - Shared types and constants for the SPI flash engine arbiter
package spi_flash_arb_pkg;

    localparam int WORD_BYTES   = 4;
    localparam int FLASH_ADDR_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_A,
        ST_BUSY_A,
        ST_ISSUE_B,
        ST_BUSY_B,
        ST_B_FIN
    } arb_state_e;

    typedef enum logic {
        GRANT_A,
        GRANT_B
    } grant_e;

endpackage

// File: rtl/spi_flash_burst_tracker.sv
// rtl/spi_flash_burst_tracker.sv - Loader burst address/remaining bookkeeping and chunk sizing
module spi_flash_burst_tracker
    import spi_flash_arb_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 24
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    load,
    input  logic [FLASH_ADDR_W-1:0] load_addr,
    input  logic [CNT_W-1:0]        load_count,
    input  logic                    advance,
    output logic [FLASH_ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]        chunk,
    output logic                    rem_zero,
    output logic                    rem_zero_next
);

    logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]        rem_q, rem_d;

    // Strobes past the end of the burst leave both registers untouched.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load) begin
            addr_d = load_addr;
            rem_d  = load_count;
        end else if (advance && (rem_q != '0)) begin
            addr_d = addr_q + FLASH_ADDR_W'(WORD_BYTES);
            rem_d  = rem_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr          = addr_q;
    assign chunk         = (rem_q < CNT_W'(MAX_BURST)) ? rem_q : CNT_W'(MAX_BURST);
    assign rem_zero      = (rem_q == '0);
    assign rem_zero_next = (rem_d == '0);

endmodule

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - Shares one spi_flash_read engine between a CPU port and a burst loader port
module spi_flash_arbiter
    import spi_flash_arb_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 24
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    a_valid,
    input  logic [FLASH_ADDR_W-1:0] a_addr,
    output logic                    a_ready,
    output logic [31:0]             a_rdata,
    input  logic                    b_req,
    input  logic [FLASH_ADDR_W-1:0] b_addr,
    input  logic [CNT_W-1:0]        b_count,
    output logic                    b_busy,
    output logic                    b_strobe,
    output logic [31:0]             b_data,
    output logic                    b_done,
    output logic                    eng_start,
    output logic [FLASH_ADDR_W-1:0] eng_address,
    output logic [CNT_W-1:0]        eng_word_count,
    input  logic                    eng_strobe,
    input  logic [31:0]             eng_data,
    input  logic                    eng_done
);

    arb_state_e              state_q, state_d;
    grant_e                  last_q, last_d;
    logic                    b_busy_q, b_busy_d;
    logic                    a_ready_q, a_ready_d;
    logic                    a_served_q, a_served_d;
    logic                    b_strobe_q, b_strobe_d;
    logic [31:0]             a_rdata_q, a_rdata_d;
    logic [31:0]             b_data_q, b_data_d;
    logic [FLASH_ADDR_W-1:0] eng_addr_q, eng_addr_d;
    logic [CNT_W-1:0]        eng_cnt_q, eng_cnt_d;

    logic                    trk_load, trk_adv, trk_rem_zero, trk_rem_zero_next;
    logic [FLASH_ADDR_W-1:0] trk_addr;
    logic [CNT_W-1:0]        trk_chunk;
    logic                    a_req, b_new, b_pend, pick_b;

    assign trk_adv = (state_q == ST_BUSY_B) && eng_strobe;

    spi_flash_burst_tracker #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_tracker (
        .clk           (clk),
        .n_reset       (n_reset),
        .load          (trk_load),
        .load_addr     (b_addr),
        .load_count    (b_count),
        .advance       (trk_adv),
        .addr          (trk_addr),
        .chunk         (trk_chunk),
        .rem_zero      (trk_rem_zero),
        .rem_zero_next (trk_rem_zero_next)
    );

    // a_valid is still high during the a_ready cycle, so it must not count as a fresh request.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        b_busy_d = b_busy_q;
        trk_load = 1'b0;
        a_req    = a_valid && !a_ready_q;
        b_new    = b_req && !b_busy_q;
        b_pend   = b_busy_q || (b_new && (b_count != '0));
        pick_b   = (a_req && b_pend) ? (last_q == GRANT_A) : (!a_req && (b_busy_q || b_new));
        unique case (state_q)
            ST_IDLE: begin
                if (pick_b) begin
                    if (b_new) begin
                        trk_load = 1'b1;
                        b_busy_d = 1'b1;
                        state_d  = (b_count == '0) ? ST_B_FIN : ST_ISSUE_B;
                    end else begin
                        state_d = ST_ISSUE_B;
                    end
                end else if (a_req) begin
                    state_d = ST_ISSUE_A;
                end
            end
            ST_ISSUE_A: state_d = ST_BUSY_A;
            ST_BUSY_A: begin
                if (eng_done) begin
                    last_d  = GRANT_A;
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE_B: state_d = ST_BUSY_B;
            ST_BUSY_B: begin
                if (eng_done) begin
                    last_d  = GRANT_B;
                    state_d = trk_rem_zero_next ? ST_B_FIN : ST_IDLE;
                end
            end
            ST_B_FIN: begin
                b_busy_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_ready_d  = (state_q == ST_BUSY_A) && eng_strobe && !a_served_q;
        a_served_d = a_served_q;
        if (state_q == ST_ISSUE_A) begin
            a_served_d = 1'b0;
        end else if (a_ready_d) begin
            a_served_d = 1'b1;
        end
        a_rdata_d  = a_ready_d ? eng_data : a_rdata_q;
        b_strobe_d = trk_adv && !trk_rem_zero;
        b_data_d   = b_strobe_d ? eng_data : b_data_q;
        eng_addr_d = eng_addr_q;
        eng_cnt_d  = eng_cnt_q;
        if (state_q == ST_ISSUE_A) begin
            eng_addr_d = a_addr;
            eng_cnt_d  = CNT_W'(1);
        end else if (state_q == ST_ISSUE_B) begin
            eng_addr_d = trk_addr;
            eng_cnt_d  = trk_chunk;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            last_q     <= GRANT_B;
            b_busy_q   <= 1'b0;
            a_ready_q  <= 1'b0;
            a_served_q <= 1'b0;
            b_strobe_q <= 1'b0;
            a_rdata_q  <= '0;
            b_data_q   <= '0;
            eng_addr_q <= '0;
            eng_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            b_busy_q   <= b_busy_d;
            a_ready_q  <= a_ready_d;
            a_served_q <= a_served_d;
            b_strobe_q <= b_strobe_d;
            a_rdata_q  <= a_rdata_d;
            b_data_q   <= b_data_d;
            eng_addr_q <= eng_addr_d;
            eng_cnt_q  <= eng_cnt_d;
        end
    end

    assign a_ready        = a_ready_q;
    assign a_rdata        = a_rdata_q;
    assign b_busy         = b_busy_q;
    assign b_strobe       = b_strobe_q;
    assign b_data         = b_data_q;
    assign b_done         = (state_q == ST_B_FIN);
    assign eng_start      = (state_q == ST_ISSUE_A) || (state_q == ST_ISSUE_B);
    assign eng_address    = eng_start ? eng_addr_d : eng_addr_q;
    assign eng_word_count = eng_start ? eng_cnt_d : eng_cnt_q;

endmodule
